// File: rtl/vga_fml_arb.sv
// Two-master FML arbiter: display refresh (LCD) and CPU bridge share one
// SDRAM controller port using round-robin arbitration on 4-beat bursts.
module vga_fml_arb #(
  parameter int fml_depth = 20
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,

  input  logic [fml_depth-1:0] lcd_fml_adr,
  input  logic                 lcd_fml_stb,
  input  logic                 lcd_fml_we,
  input  logic [1:0]           lcd_fml_sel,
  input  logic [15:0]          lcd_fml_do,
  output logic                 lcd_fml_ack,
  output logic [15:0]          lcd_fml_di,

  input  logic [fml_depth-1:0] cpu_fml_adr,
  input  logic                 cpu_fml_stb,
  input  logic                 cpu_fml_we,
  input  logic [1:0]           cpu_fml_sel,
  input  logic [15:0]          cpu_fml_do,
  output logic                 cpu_fml_ack,
  output logic [15:0]          cpu_fml_di,

  output logic [fml_depth-1:0] fml_adr,
  output logic                 fml_stb,
  output logic                 fml_we,
  output logic [1:0]           fml_sel,
  output logic [15:0]          fml_do,
  input  logic                 fml_ack,
  input  logic [15:0]          fml_di
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_LCD,
    S_ADDR_CPU,
    S_DATA_LCD,
    S_DATA_CPU
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_next;
  logic       r_last_grant;   // 0 = LCD, 1 = CPU
  logic       w_last_grant_next;
  logic       w_busy;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_last_grant <= w_last_grant_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_last_grant_next = r_last_grant;
    case (r_state)
      S_IDLE: begin
        // On a tie the master that did not win last time takes the bus.
        if (lcd_fml_stb && (!cpu_fml_stb || r_last_grant)) begin
          w_state_next      = S_ADDR_LCD;
          w_last_grant_next = 1'b0;
        end else if (cpu_fml_stb) begin
          w_state_next      = S_ADDR_CPU;
          w_last_grant_next = 1'b1;
        end
      end
      S_ADDR_LCD: begin
        if (!lcd_fml_stb) begin
          w_state_next = S_IDLE;
        end else if (fml_ack) begin
          w_state_next = S_DATA_LCD;
          w_cnt_next   = 2'd2;
        end
      end
      S_ADDR_CPU: begin
        if (!cpu_fml_stb) begin
          w_state_next = S_IDLE;
        end else if (fml_ack) begin
          w_state_next = S_DATA_CPU;
          w_cnt_next   = 2'd2;
        end
      end
      S_DATA_LCD, S_DATA_CPU: begin
        if (r_cnt == 2'd0) begin
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt - 2'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Address/control follow the grant register rather than the state, so they
  // stay stable through the data beats of a burst.
  assign fml_adr = r_last_grant ? cpu_fml_adr : lcd_fml_adr;
  assign fml_we  = r_last_grant ? cpu_fml_we  : lcd_fml_we;
  assign fml_sel = r_last_grant ? cpu_fml_sel : lcd_fml_sel;

  assign fml_stb = ((r_state == S_ADDR_LCD) && lcd_fml_stb) ||
                   ((r_state == S_ADDR_CPU) && cpu_fml_stb);

  assign w_busy = (r_state != S_IDLE);
  assign fml_do = w_busy ? (r_last_grant ? cpu_fml_do : lcd_fml_do) : '0;

  assign lcd_fml_ack = (r_state == S_ADDR_LCD) && lcd_fml_stb && fml_ack;
  assign cpu_fml_ack = (r_state == S_ADDR_CPU) && cpu_fml_stb && fml_ack;

  assign lcd_fml_di = fml_di;
  assign cpu_fml_di = fml_di;

endmodule

// File: tb/tb_vga_fml_arb.sv
// Directed bench for vga_fml_arb: expected ack events are queued by the
// stimulus and checked by an independent monitor when an ack appears.
module tb_vga_fml_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] lcd_adr, cpu_adr, fml_adr;
  logic        lcd_stb, lcd_we, lcd_ack, cpu_stb, cpu_we, cpu_ack;
  logic [1:0]  lcd_sel, cpu_sel, fml_sel;
  logic [15:0] lcd_do, lcd_di, cpu_do, cpu_di, fml_do, fml_di;
  logic        fml_stb, fml_we, fml_ack;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        m;
    logic [19:0] adr;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] dout;
    logic [15:0] di;
  } ev_t;

  ev_t exp_q[$];

  always #5 clk = ~clk;

  vga_fml_arb #(.fml_depth(20)) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .lcd_fml_adr(lcd_adr),
    .lcd_fml_stb(lcd_stb),
    .lcd_fml_we (lcd_we),
    .lcd_fml_sel(lcd_sel),
    .lcd_fml_do (lcd_do),
    .lcd_fml_ack(lcd_ack),
    .lcd_fml_di (lcd_di),
    .cpu_fml_adr(cpu_adr),
    .cpu_fml_stb(cpu_stb),
    .cpu_fml_we (cpu_we),
    .cpu_fml_sel(cpu_sel),
    .cpu_fml_do (cpu_do),
    .cpu_fml_ack(cpu_ack),
    .cpu_fml_di (cpu_di),
    .fml_adr    (fml_adr),
    .fml_stb    (fml_stb),
    .fml_we     (fml_we),
    .fml_sel    (fml_sel),
    .fml_do     (fml_do),
    .fml_ack    (fml_ack),
    .fml_di     (fml_di)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic m, input logic [19:0] adr, input logic we,
                      input logic [1:0] sel, input logic [15:0] dout, input logic [15:0] di);
    ev_t e;
    e.m = m; e.adr = adr; e.we = we; e.sel = sel; e.dout = dout; e.di = di;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    if (lcd_ack || cpu_ack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", {30'd0, lcd_ack, cpu_ack}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_master", {30'd0, lcd_ack, cpu_ack}, e.m ? 32'd1 : 32'd2);
        chk("ack_adr", {12'd0, fml_adr}, {12'd0, e.adr});
        chk("ack_we", {31'd0, fml_we}, {31'd0, e.we});
        chk("ack_sel", {30'd0, fml_sel}, {30'd0, e.sel});
        chk("ack_do", {16'd0, fml_do}, {16'd0, e.dout});
        chk("ack_di", {16'd0, e.m ? cpu_di : lcd_di}, {16'd0, e.di});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fml_ack = 1'b0; fml_di = '0;
    lcd_adr = 20'h11111; lcd_stb = 1'b1; lcd_we = 1'b0; lcd_sel = 2'b11; lcd_do = 16'h5A5A;
    cpu_adr = 20'h22222; cpu_stb = 1'b0; cpu_we = 1'b0; cpu_sel = 2'b01; cpu_do = 16'h0000;
    cyc(2);
    chk("rst_stb", {31'd0, fml_stb}, 32'd0);
    chk("rst_lcd_ack", {31'd0, lcd_ack}, 32'd0);
    chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst_do", {16'd0, fml_do}, 32'd0);

    // Tie after reset: LCD wins; cycle numbering relative to release.
    cpu_stb = 1'b1;
    rst = 1'b0;
    #1 chk("c0_idle_stb", {31'd0, fml_stb}, 32'd0);
    cyc(); chk("c1_stb", {31'd0, fml_stb}, 32'd1);
    chk("c1_adr", {12'd0, fml_adr}, 32'h11111);
    cyc(); chk("c2_stb", {31'd0, fml_stb}, 32'd1);
    cyc(); fml_ack = 1'b1; fml_di = 16'h1234;
    push(1'b0, 20'h11111, 1'b0, 2'b11, 16'h5A5A, 16'h1234);
    #1 chk("c3_cpu_di_bcast", {16'd0, cpu_di}, 32'h1234);
    cyc(); fml_ack = 1'b0; lcd_stb = 1'b0;
    #1 chk("c4_data_stb", {31'd0, fml_stb}, 32'd0);
    cyc(); chk("c5_adr_hold", {12'd0, fml_adr}, 32'h11111);
    chk("c5_data_do", {16'd0, fml_do}, 32'h5A5A);
    cyc(); chk("c6_data_stb", {31'd0, fml_stb}, 32'd0);
    cyc(); chk("c7_idle_stb", {31'd0, fml_stb}, 32'd0);
    chk("c7_idle_do", {16'd0, fml_do}, 32'd0);
    cpu_we = 1'b1; cpu_sel = 2'b11; cpu_do = 16'hA5A5;

    // CPU write burst, then spurious acks in DATA_CPU and IDLE.
    cyc(); chk("w_stb", {31'd0, fml_stb}, 32'd1);
    chk("w_adr", {12'd0, fml_adr}, 32'h22222);
    chk("w_we", {31'd0, fml_we}, 32'd1);
    fml_ack = 1'b1; fml_di = '0;
    push(1'b1, 20'h22222, 1'b1, 2'b11, 16'hA5A5, 16'h0000);
    cyc(); cpu_stb = 1'b0; cpu_do = 16'hA5A6;
    #1 chk("w_beat1_do", {16'd0, fml_do}, 32'hA5A6);
    chk("w_beat1_stb", {31'd0, fml_stb}, 32'd0);
    cyc(); fml_ack = 1'b0; cpu_do = 16'hA5A7;
    #1 chk("w_beat2_do", {16'd0, fml_do}, 32'hA5A7);
    cyc(); cpu_do = 16'hA5A8;
    #1 chk("w_beat3_do", {16'd0, fml_do}, 32'hA5A8);
    cyc(); chk("w_idle_stb", {31'd0, fml_stb}, 32'd0);
    chk("w_idle_do", {16'd0, fml_do}, 32'd0);
    fml_ack = 1'b1;
    cyc(); fml_ack = 1'b0;
    chk("idle_ack_ignored", {31'd0, fml_stb}, 32'd0);

    // Round-robin with both masters requesting continuously.
    cpu_we = 1'b0; cpu_sel = 2'b01; cpu_do = 16'h0000;
    lcd_stb = 1'b1; cpu_stb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic        m;
      logic [19:0] a;
      logic [1:0]  s;
      logic [15:0] d;
      m = k[0];
      a = m ? 20'h22222 : 20'h11111;
      s = m ? 2'b01 : 2'b11;
      d = m ? 16'h0000 : 16'h5A5A;
      #1 chk("rr_idle_stb", {31'd0, fml_stb}, 32'd0);
      cyc(); chk("rr_addr_stb", {31'd0, fml_stb}, 32'd1);
      chk("rr_adr", {12'd0, fml_adr}, {12'd0, a});
      cyc(2); fml_ack = 1'b1; fml_di = 16'h0100 + 16'(k);
      push(m, a, 1'b0, s, d, 16'h0100 + 16'(k));
      cyc(); fml_ack = 1'b0;
      cyc(3);
    end

    // Granted master drops stb before the slave acks.
    cpu_stb = 1'b0;
    cyc(); chk("viol_addr_stb", {31'd0, fml_stb}, 32'd1);
    lcd_stb = 1'b0; fml_ack = 1'b1;
    #1 chk("viol_stb_follow", {31'd0, fml_stb}, 32'd0);
    cyc(); fml_ack = 1'b0; cpu_stb = 1'b1;
    chk("viol_idle_stb", {31'd0, fml_stb}, 32'd0);
    cyc(); chk("viol_cpu_stb", {31'd0, fml_stb}, 32'd1);
    chk("viol_cpu_adr", {12'd0, fml_adr}, 32'h22222);
    fml_ack = 1'b1; fml_di = 16'hCAFE;
    push(1'b1, 20'h22222, 1'b0, 2'b01, 16'h0000, 16'hCAFE);
    cyc(); fml_ack = 1'b0; cpu_stb = 1'b0;
    cyc(3);

    // Reset during DATA_LCD beat 2 with a CPU request pending.
    lcd_we = 1'b1; lcd_do = 16'hBEEF; lcd_stb = 1'b1;
    cyc(); chk("r_addr_stb", {31'd0, fml_stb}, 32'd1);
    fml_ack = 1'b1; fml_di = '0;
    push(1'b0, 20'h11111, 1'b1, 2'b11, 16'hBEEF, 16'h0000);
    cyc(); fml_ack = 1'b0; lcd_stb = 1'b0; cpu_stb = 1'b1;
    cyc(); rst = 1'b1;
    #1 chk("r_mid_stb", {31'd0, fml_stb}, 32'd0);
    chk("r_mid_do", {16'd0, fml_do}, 32'd0);
    chk("r_mid_acks", {30'd0, lcd_ack, cpu_ack}, 32'd0);
    cyc(); chk("r_hold_stb", {31'd0, fml_stb}, 32'd0);
    rst = 1'b0;
    #1 chk("r_rel_idle_stb", {31'd0, fml_stb}, 32'd0);
    cyc(); chk("r_cpu_stb", {31'd0, fml_stb}, 32'd1);
    chk("r_cpu_adr", {12'd0, fml_adr}, 32'h22222);
    fml_ack = 1'b1; fml_di = 16'h0BAD;
    push(1'b1, 20'h22222, 1'b0, 2'b01, 16'h0000, 16'h0BAD);
    cyc(); fml_ack = 1'b0; cpu_stb = 1'b0;
    cyc(4);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fml_arb.md
VGA_FML_ARB -- requirements
Module: vga_fml_arb

Interface
REQ-001 SHALL have parameter fml_depth, default 20, FML byte-address width (1MB video memory).
REQ-002 SHALL have port sys_clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port sys_rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports lcd_fml_adr in fml_depth, lcd_fml_stb in 1, lcd_fml_we in 1, lcd_fml_sel in 2, lcd_fml_do in 16: master 0 (display refresh) request.
REQ-005 SHALL have ports lcd_fml_ack out 1, lcd_fml_di out 16: master 0 response.
REQ-006 SHALL have ports cpu_fml_adr in fml_depth, cpu_fml_stb in 1, cpu_fml_we in 1, cpu_fml_sel in 2, cpu_fml_do in 16: master 1 (CPU bridge) request.
REQ-007 SHALL have ports cpu_fml_ack out 1, cpu_fml_di out 16: master 1 response.
REQ-008 SHALL have ports fml_adr out fml_depth, fml_stb out 1, fml_we out 1, fml_sel out 2, fml_do out 16: slave (SDRAM controller) request.
REQ-009 SHALL have ports fml_ack in 1, fml_di in 16: slave response.

Function
REQ-010 SHALL implement FML bursts of exactly 4 beats; slave fml_ack marks beat 0, beats 1-3 occupy the 3 following cycles.
REQ-011 SHALL implement states IDLE, ADDR_LCD, ADDR_CPU, DATA_LCD, DATA_CPU.
REQ-012 IDLE: no request -> stay; any stb -> ADDR_x of the winner next cycle; fml_stb=0 in IDLE.
REQ-013 SHALL arbitrate round-robin using register last_grant: both stb in IDLE -> master not equal to last_grant wins; single stb -> that master wins.
REQ-014 last_grant SHALL update to the winner on entry to ADDR_x.
REQ-015 ADDR_x: fml_adr/fml_we/fml_sel/fml_stb SHALL combinationally follow the granted master; other master ignored.
REQ-016 ADDR_x: fml_ack SHALL route combinationally to granted master's ack only; ungranted ack always 0.
REQ-017 ADDR_x with fml_ack=1 -> DATA_x, 2-bit beat counter loaded with 2.
REQ-018 ADDR_x with granted stb deasserted before ack (protocol violation) -> IDLE next cycle, no ack forwarded.
REQ-019 DATA_x: fml_stb SHALL be 0; counter decrements each cycle; counter==0 -> IDLE next cycle (3 cycles in DATA_x).
REQ-020 fml_do SHALL mux granted master's do in ADDR_x and DATA_x (write beats 0-3); 0 in IDLE.
REQ-021 fml_di SHALL broadcast unregistered to lcd_fml_di and cpu_fml_di at all times; masters qualify by own ack/burst timing.
REQ-022 fml_adr/we/sel SHALL hold granted master's values through DATA_x (mux by grant, not state).
REQ-023 Burst-to-burst gap SHALL be exactly 1 IDLE cycle; request-to-fml_stb latency 1 cycle.
REQ-024 fml_ack arriving in IDLE or DATA_x SHALL be ignored (no ack forwarded, no state change).
REQ-025 Master stb changes during DATA_x SHALL not affect the current burst.

Reset
REQ-026 sys_rst=1 SHALL asynchronously force state IDLE, counter 0, last_grant=CPU (LCD wins first tie).
REQ-027 During/after reset fml_stb, lcd_fml_ack, cpu_fml_ack SHALL be 0, fml_do 0; reset mid-burst aborts burst without further acks.
REQ-028 Release of sys_rst SHALL take effect on next rising sys_clk; first arbitration on first edge after release.

Verification
REQ-029 Tie after reset: both stb=1 in IDLE, fml_ack at cycle 3 -> ADDR_LCD, fml_adr=lcd_fml_adr, lcd_fml_ack=1 cycle 3 only, cpu_fml_ack=0, IDLE at cycle 7.
REQ-030 Round-robin: both stb held continuously, slave acks 2 cycles after stb -> grants alternate LCD, CPU, LCD, CPU with one IDLE cycle between bursts.
REQ-031 CPU write: cpu_fml_we=1, sel=2'b11, do=16'hA5A5..16'hA5A8 over 4 beats -> fml_we=1, fml_do shows same 4 words on ack cycle and 3 following cycles.
REQ-032 LCD read: fml_di=16'h1234 on beat 0 -> lcd_fml_di=cpu_fml_di=16'h1234 same cycle; only lcd_fml_ack pulses.
REQ-033 Spurious fml_ack=1 in IDLE and in DATA_CPU -> no ack on either master, state sequence unchanged.
REQ-034 sys_rst asserted in DATA_LCD beat 2 -> fml_stb and acks 0 immediately, state IDLE; after release, pending CPU stb granted next edge.
